// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants and the frame state encoding.
// The RX block imports the same package.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: o_tick pulses for one cycle at the end of every CLK_DIV-cycle bit.
// i_restart realigns the bit period so the next tick lands CLK_DIV cycles later.
module uart_baud_tick #(
  parameter int CLK_DIV = 5000
) (
  input  logic clk,
  input  logic res,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (res || i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits; back-to-back frames with no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 5000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 en_data_in,
  output logic                 in_ready,
  output logic                 TX,
  output logic                 busy
);

  localparam logic       HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t          r_state, w_state;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [2:0]           r_bit,   w_bit;
  logic                 r_par,   w_par;
  logic                 r_tx,    w_tx;
  logic                 r_busy,  w_busy;

  logic w_tick;
  logic w_last_stop;
  logic w_accept;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .res      (res),
    .i_restart(w_accept),
    .o_tick   (w_tick)
  );

  // Ready in IDLE and in the final cycle of the last stop bit, so a waiting word
  // chains straight into the next start bit.
  assign w_last_stop = (r_state == ST_STOP) && w_tick && (r_bit == LAST_STOP);
  assign in_ready    = (r_state == ST_IDLE) || w_last_stop;
  assign w_accept    = en_data_in && in_ready;

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit   <= w_bit;
      r_par   <= w_par;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bit   = r_bit;
    w_par   = r_par;
    w_tx    = r_tx;
    w_busy  = r_busy;

    if (w_accept) begin
      w_state = ST_START;
      w_shift = data_in;
      w_bit   = '0;
      w_par   = (PARITY == PARITY_ODD) ? ~^data_in : ^data_in;
      w_tx    = 1'b0;
      w_busy  = 1'b1;
    end else if (w_tick) begin
      case (r_state)
        ST_START: begin
          w_state = ST_DATA;
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
          w_bit   = '0;
        end
        ST_DATA: begin
          if (r_bit == LAST_DATA) begin
            w_state = HAS_PAR ? ST_PARITY : ST_STOP;
            w_tx    = HAS_PAR ? r_par : 1'b1;
            w_bit   = '0;
          end else begin
            w_tx    = r_shift[0];
            w_shift = r_shift >> 1;
            w_bit   = r_bit + 1'b1;
          end
        end
        ST_PARITY: begin
          w_state = ST_STOP;
          w_tx    = 1'b1;
          w_bit   = '0;
        end
        ST_STOP: begin
          if (r_bit == LAST_STOP) begin
            w_state = ST_IDLE;
            w_busy  = 1'b0;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
        default: begin
          w_state = ST_IDLE;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
        end
      endcase
    end
  end

  assign TX   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 5N2) with CLK_DIV=4;
// expected frames are built from the framing rules and checked cycle by cycle on TX/busy/in_ready.
module tb_uart_tx_frame;

  localparam int CD = 4;
  localparam int N  = 4;
  localparam int DB_T  [N] = '{8, 8, 8, 5};
  localparam int PAR_T [N] = '{0, 1, 2, 0};
  localparam int SB_T  [N] = '{1, 1, 1, 2};

  typedef struct packed {
    logic [15:0] bits;
    logic [7:0]  len;
    logic [31:0] acc;
  } frame_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       res [N];
  logic       en  [N];
  logic [7:0] din [N];
  logic       rdy [N];
  logic       tx  [N];
  logic       bsy [N];

  frame_t exp_q [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", name, g, cyc, act, expv);
    end
  endtask

  // Line sequence of a whole frame, one entry per bit period, from the framing rules.
  function automatic frame_t ref_frame(input int g, input logic [7:0] d, input int acc);
    frame_t f;
    int     n = 0;
    logic   p = 1'b0;
    f.bits = '0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < DB_T[g]; i++) begin
      f.bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (PAR_T[g] != 0) begin
      f.bits[n] = (PAR_T[g] == 2) ? ~p : p;
      n++;
    end
    for (int s = 0; s < SB_T[g]; s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = 8'(n);
    f.acc = 32'(acc);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst(input int g, input int n);
    en[g]  = 1'b0;
    res[g] = 1'b1;
    repeat (n) tick();
    res[g] = 1'b0;
  endtask

  task automatic idle(input int g, input int n);
    en[g] = 1'b0;
    repeat (n) begin
      din[g] = 8'($urandom);
      tick();
    end
  endtask

  // Holds valid until accepted; valid stays high on return so calls can chain.
  task automatic send(input int g, input logic [7:0] d);
    int n = 0;
    en[g]  = 1'b1;
    din[g] = d;
    while (!rdy[g] || res[g]) begin
      tick();
      n++;
      if (n > 500) begin
        check("accept_timeout", g, 32'd0, 32'd1);
        en[g] = 1'b0;
        return;
      end
    end
    exp_q[g].push_back(ref_frame(g, d, cyc + 1));
    tick();
  endtask

  task automatic pulse(input int g, input logic [7:0] d);
    en[g]  = 1'b1;
    din[g] = d;
    if (rdy[g] && !res[g]) exp_q[g].push_back(ref_frame(g, d, cyc + 1));
    tick();
    en[g] = 1'b0;
  endtask

  task automatic drive(input int g);
    tick();
    rst(g, 3);
    if (g == 0) begin
      send(0, 8'($urandom));
      idle(0, 15);
      rst(0, 2);
      send(0, 8'h0A);
      idle(0, 45);
      send(0, 8'h55);
      send(0, 8'hC3);
      idle(0, 50);
      send(0, 8'h3C);
      idle(0, 12);
      pulse(0, 8'hFF);
      idle(0, 40);
      send(0, 8'h96);
      idle(0, 9);
      rst(0, 1);
      idle(0, 2);
      send(0, 8'h69);
      idle(0, 45);
    end else begin
      send(g, (g == 3) ? 8'h13 : 8'hA5);
      idle(g, 50);
    end
    repeat (10) begin
      send(g, 8'($urandom));
      idle(g, $urandom_range(0, 3));
    end
    idle(g, 60);
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_frame #(
      .CLK_DIV  (CD),
      .DATA_BITS(DB_T[g]),
      .PARITY   (PAR_T[g]),
      .STOP_BITS(SB_T[g])
    ) u_dut (
      .clk       (clk),
      .res       (res[g]),
      .data_in   (din[g][DB_T[g]-1:0]),
      .en_data_in(en[g]),
      .in_ready  (rdy[g]),
      .TX        (tx[g]),
      .busy      (bsy[g])
    );

    initial begin : mon
      frame_t     cur;
      int         idx;
      logic       active;
      logic [2:0] ev;
      active = 1'b0;
      idx    = 0;
      cur    = '0;
      forever begin
        @(negedge clk);
        if (res[g]) begin
          active = 1'b0;
          exp_q[g].delete();
          continue;
        end
        if (!active) begin
          if (tx[g] == 1'b0) begin
            if (exp_q[g].size() == 0) begin
              check("unexpected_start", g, 32'd1, 32'd0);
            end else begin
              cur = exp_q[g].pop_front();
              check("start_latency", g, 32'(cyc), cur.acc);
              active = 1'b1;
              idx    = 0;
            end
          end else begin
            check("idle_lines", g, {29'd0, tx[g], bsy[g], rdy[g]}, 32'b101);
          end
        end
        if (active) begin
          ev = {cur.bits[idx / CD], 1'b1, (idx == int'(cur.len) * CD - 1)};
          check("frame_lines", g, {29'd0, tx[g], bsy[g], rdy[g]}, {29'd0, ev});
          idx++;
          if (idx == int'(cur.len) * CD) active = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < N; g++) begin
      res[g] = 1'b1;
      en[g]  = 1'b0;
      din[g] = '0;
    end
    fork
      drive(0);
      drive(1);
      drive(2);
      drive(3);
    join
    repeat (5) @(posedge clk);
    for (int g = 0; g < N; g++) check("queue_drained", g, 32'(exp_q[g].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
